// File: rtl/soc_system_pio_in_debounce_irq.sv
// Avalon-MM input PIO for the Nios subsystem: synchronised, per-bit debounced inputs
// with maskable rising/falling edge capture and a level interrupt.
module soc_system_pio_in_debounce_irq #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_RAW       = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
   localparam logic [2:0] ADDR_RISE_EN   = 3'd4;
   localparam logic [2:0] ADDR_FALL_EN   = 3'd5;

   generate
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("WIDTH must be 1..32");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
         $error("SYNC_STAGES must be 2..3");
      end
      if (DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
         $error("DEBOUNCE_CYCLES must be 0..65535");
      end
   endgenerate

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] edge_cap_q;
   logic [WIDTH-1:0] rise_en_q;
   logic [WIDTH-1:0] fall_en_q;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect && !write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign raw = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) data_q <= '0;
            else          data_q <= raw;
         end
      end else begin : g_debounce
         // Counter saturates at N-1: the Nth differing clock accepts and clears it.
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] cnt_q [WIDTH];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_q <= '0;
               for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (raw[i] == data_q[i]) begin
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     data_q[i] <= raw[i];
                     cnt_q[i]  <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   assign edge_set = (data_q & ~prev_q & rise_en_q) | (~data_q & prev_q & fall_en_q);
   assign cap_clr  = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q     <= '0;
         edge_cap_q <= '0;
         irq_mask_q <= '0;
         rise_en_q  <= '1;
         fall_en_q  <= '1;
      end else begin
         prev_q     <= data_q;
         // A fresh edge outranks a simultaneous software clear.
         edge_cap_q <= edge_set | (edge_cap_q & ~cap_clr);
         if (wr_en && address == ADDR_IRQ_MASK) irq_mask_q <= wdata;
         if (wr_en && address == ADDR_RISE_EN)  rise_en_q  <= wdata;
         if (wr_en && address == ADDR_FALL_EN)  fall_en_q  <= wdata;
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:     rd_next[WIDTH-1:0] = data_q;
         ADDR_RAW:      rd_next[WIDTH-1:0] = raw;
         ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask_q;
         ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = edge_cap_q;
         ADDR_RISE_EN:  rd_next[WIDTH-1:0] = rise_en_q;
         ADDR_FALL_EN:  rd_next[WIDTH-1:0] = fall_en_q;
         default:       rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_in_debounce_irq.sv
// Scoreboarded bench for the debounced input PIO (WIDTH=4, SYNC_STAGES=2, N=4).
module tb_soc_system_pio_in_debounce_irq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = '0;
   logic [31:0] readdata;
   logic        irq;
   logic        rd_req = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] exp_rd;
      bit          do_irq;
      bit          exp_irq;
   } chk_t;

   chk_t sb[$];

   soc_system_pio_in_debounce_irq #(
      .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Readdata expectation is the register value now; irq expectation is after the coming edge.
   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm,
                     input bit ci = 1'b0, input bit ei = 1'b0);
      chk_t c;
      c.name = nm; c.exp_rd = e; c.do_irq = ci; c.exp_irq = ei;
      sb.push_back(c);
      address = a;
      rd_req  = 1'b1;
      @(negedge clk);
      rd_req  = 1'b0;
   endtask

   initial begin : monitor
      chk_t c;
      bit   fire;
      forever begin
         @(posedge clk);
         fire = rd_req;
         #1;
         if (fire) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow got readdata=%h with no expectation", readdata);
            end else begin
               c = sb.pop_front();
               if (readdata !== c.exp_rd) begin
                  errors++;
                  $display("FAIL %s readdata got %h exp %h", c.name, readdata, c.exp_rd);
               end
               if (c.do_irq) begin
                  checks++;
                  if (irq !== c.exp_irq) begin
                     errors++;
                     $display("FAIL %s irq got %b exp %b", c.name, irq, c.exp_irq);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] rst_vals [8];
      rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'hF, 32'h0, 32'h0};

      // 1: reset values
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) rd(3'(i), rst_vals[i], $sformatf("rst_addr%0d", i), 1'b1, 1'b0);

      // 2: 3-clock glitch rejected
      in_port = 4'h1;
      tick(3);
      in_port = 4'h0;
      tick(10);
      rd(3'd0, 32'h0, "glitch_data", 1'b1, 1'b0);
      rd(3'd3, 32'h0, "glitch_cap");
      rd(3'd1, 32'h0, "glitch_raw");

      // 3: accepted change, capture and irq, W1C
      wr(3'd2, 32'h1);
      in_port = 4'h5;
      tick(5);
      rd(3'd0, 32'h0, "data_before_n", 1'b1, 1'b0);
      rd(3'd3, 32'h0, "cap_before", 1'b1, 1'b1);
      rd(3'd0, 32'h5, "data_after_n");
      rd(3'd1, 32'h5, "raw_after");
      rd(3'd3, 32'h5, "cap_after", 1'b1, 1'b1);
      wr(3'd3, 32'h1);
      rd(3'd3, 32'h4, "cap_w1c", 1'b1, 1'b0);

      // 4: rise disabled, fall on bit1 only
      wr(3'd4, 32'h0);
      wr(3'd5, 32'h2);
      in_port = 4'h0;
      tick(10);
      wr(3'd3, 32'hF);
      rd(3'd3, 32'h0, "cap_cleared");
      in_port = 4'h2;
      tick(10);
      rd(3'd0, 32'h2, "rise_data");
      rd(3'd3, 32'h0, "rise_masked", 1'b1, 1'b0);
      in_port = 4'h0;
      tick(5);
      rd(3'd3, 32'h0, "fall_pre1");
      rd(3'd3, 32'h0, "fall_pre2", 1'b1, 1'b0);
      rd(3'd3, 32'h2, "fall_cap");

      // 5: clear coinciding with a new edge
      in_port = 4'h2;
      tick(10);
      wr(3'd3, 32'h2);
      rd(3'd3, 32'h0, "race_setup");
      in_port = 4'h0;
      tick(6);
      wr(3'd3, 32'h2);
      rd(3'd3, 32'h2, "race_edge_wins");
      wr(3'd2, 32'h2);
      rd(3'd2, 32'h2, "mask_irq", 1'b1, 1'b1);
      wr(3'd6, 32'hFF);
      wr(3'd0, 32'hF);
      rd(3'd6, 32'h0, "addr6_ignored");
      rd(3'd0, 32'h0, "ro_ignored");

      // 6: reset mid-debounce
      in_port = 4'hF;
      tick(4);
      reset_n = 1'b0;
      rd(3'd0, 32'h0, "in_reset", 1'b1, 1'b0);
      tick(1);
      reset_n = 1'b1;
      tick(5);
      rd(3'd0, 32'h0, "post_rst_pre", 1'b1, 1'b0);
      rd(3'd3, 32'h0, "post_rst_cap_pre", 1'b1, 1'b0);
      rd(3'd0, 32'hF, "post_rst_data");
      rd(3'd3, 32'hF, "post_rst_cap");
      rd(3'd2, 32'h0, "post_rst_mask", 1'b1, 1'b0);
      rd(3'd4, 32'hF, "post_rst_rise");
      rd(3'd5, 32'hF, "post_rst_fall");

      tick(2);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
